// File: rtl/peripheral_endpoint.sv
// peripheral_endpoint
//   Device-side responder on the peripheral bus. It answers requests whose
//   bus_device matches DEVICE_ID and completes each one with a four-phase
//   req/ack handshake:
//     - a bus WRITE pushes into the RX FIFO, which the local peripheral drains;
//     - a bus READ pops the TX FIFO, which the local peripheral fills;
//     - a bus STATUS reports both FIFO levels.
//   All bus outputs are registered. bus_rdata is zero whenever bus_ack is low,
//   so several endpoints can share an OR-ed read bus.
//
// Ports
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   bus_req          master request (device/command/wdata stable while high)
//   bus_device       target device address
//   bus_command      6'h00 READ, 6'h01 WRITE, 6'h02 STATUS, others illegal
//   bus_wdata        write payload
//   bus_rdata        read/status payload, valid while bus_ack=1, else 0
//   bus_ack          request complete
//   bus_err          qualifies bus_ack: request rejected, no side effect
//   loc_rx_data      RX FIFO head
//   loc_rx_valid     RX FIFO not empty
//   loc_rx_ready     local pop of the RX FIFO
//   loc_tx_data      local data for the bus to read
//   loc_tx_valid     local push into the TX FIFO
//   loc_tx_ready     TX FIFO not full
module peripheral_endpoint #(
  parameter logic [4:0]  DEVICE_ID  = 5'd1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_req,
  input  logic [4:0]  bus_device,
  input  logic [5:0]  bus_command,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        bus_err,
  output logic [31:0] loc_rx_data,
  output logic        loc_rx_valid,
  input  logic        loc_rx_ready,
  input  logic [31:0] loc_tx_data,
  input  logic        loc_tx_valid,
  output logic        loc_tx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  localparam logic [5:0] CMD_READ   = 6'h00;
  localparam logic [5:0] CMD_WRITE  = 6'h01;
  localparam logic [5:0] CMD_STATUS = 6'h02;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ACK
  } state_t;

  state_t state, state_next;

  logic [31:0]   rx_mem [FIFO_DEPTH];
  logic [31:0]   tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] rx_count, tx_count;

  logic        rx_full, tx_empty;
  logic        rx_push, rx_pop, tx_push, tx_pop;
  logic        ack_next, err_next;
  logic [31:0] rdata_next;
  logic [31:0] status_word;

  assign rx_full  = (rx_count == FULL_COUNT);
  assign tx_empty = (tx_count == '0);

  assign status_word = {14'b0, tx_empty, rx_full,
                        3'b0, 5'(tx_count), 3'b0, 5'(rx_count)};

  // Local-side handshakes look only at the registered counts, so a bus
  // access in the same cycle never turns a full/empty FIFO into a legal one.
  assign rx_pop       = loc_rx_ready && (rx_count != '0);
  assign tx_push      = loc_tx_valid && !(tx_count == FULL_COUNT);
  assign loc_tx_ready = !(tx_count == FULL_COUNT);
  assign loc_rx_valid = (rx_count != '0);
  assign loc_rx_data  = rx_mem[rx_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_ack   <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
    end else begin
      state     <= state_next;
      bus_ack   <= ack_next;
      bus_err   <= err_next;
      bus_rdata <= rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    ack_next   = bus_ack;
    err_next   = bus_err;
    rdata_next = bus_rdata;
    rx_push    = 1'b0;
    tx_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (bus_req && (bus_device == DEVICE_ID)) state_next = EXEC;
      end
      EXEC: begin
        // Commits regardless of bus_req; a request withdrawn here still
        // produces a single-cycle ack.
        state_next = ACK;
        ack_next   = 1'b1;
        err_next   = 1'b0;
        rdata_next = '0;
        case (bus_command)
          CMD_READ: begin
            if (!tx_empty) begin
              rdata_next = tx_mem[tx_rd_ptr];
              tx_pop     = 1'b1;
            end else begin
              err_next = 1'b1;
            end
          end
          CMD_WRITE: begin
            if (!rx_full) rx_push = 1'b1;
            else          err_next = 1'b1;
          end
          CMD_STATUS: rdata_next = status_word;
          default:    err_next = 1'b1;
        endcase
      end
      ACK: begin
        if (!bus_req) begin
          state_next = IDLE;
          ack_next   = 1'b0;
          err_next   = 1'b0;
          rdata_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + AW'(1);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus_wdata;
    if (tx_push) tx_mem[tx_wr_ptr] <= loc_tx_data;
  end

endmodule

// File: tb/tb_peripheral_endpoint.sv
module tb_peripheral_endpoint;

  localparam int DEPTH = 4;
  localparam logic [5:0] RD = 6'h00, WR = 6'h01, ST = 6'h02;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic [4:0]  bus_device;
  logic [5:0]  bus_command;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] loc_rx_data;
  logic        loc_rx_valid;
  logic        loc_rx_ready;
  logic [31:0] loc_tx_data;
  logic        loc_tx_valid;
  logic        loc_tx_ready;

  int unsigned checks = 0;
  int unsigned passed = 0;

  logic [31:0] rxq[$];
  logic [31:0] txq[$];

  peripheral_endpoint #(.DEVICE_ID(5'd1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .bus_req(bus_req), .bus_device(bus_device), .bus_command(bus_command),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
    .loc_rx_data(loc_rx_data), .loc_rx_valid(loc_rx_valid), .loc_rx_ready(loc_rx_ready),
    .loc_tx_data(loc_tx_data), .loc_tx_valid(loc_tx_valid), .loc_tx_ready(loc_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what one executed bus command does to the two queues,
  // with all full/empty decisions taken on the levels before the edge.
  task automatic model_exec(input logic [5:0] cmd, input logic [31:0] wdata,
                            input logic lpop, input logic lpush, input logic [31:0] lpd,
                            output logic xe, output logic [31:0] xr);
    int rxn = rxq.size();
    int txn = txq.size();
    xe = 1'b0;
    xr = '0;
    if (cmd == RD) begin
      if (txn > 0) xr = txq.pop_front();
      else         xe = 1'b1;
    end else if (cmd == WR) begin
      if (rxn >= DEPTH) xe = 1'b1;
    end else if (cmd == ST) begin
      xr = (((txn == 0) ? 1 : 0) << 17) + (((rxn == DEPTH) ? 1 : 0) << 16)
           + (txn << 8) + rxn;
    end else begin
      xe = 1'b1;
    end
    if (lpop && rxn > 0) void'(rxq.pop_front());
    if (cmd == WR && rxn < DEPTH) rxq.push_back(wdata);
    if (lpush && txn < DEPTH) txq.push_back(lpd);
  endtask

  // Drives one complete request. a1: ack one edge after req; a2/e2/r2: outputs
  // after the executing edge; a3/r3: outputs one edge after req is dropped.
  task automatic bus_txn(input logic [4:0] dev, input logic [5:0] cmd, input logic [31:0] wdata,
                         input logic lpop, input logic lpush, input logic [31:0] lpd,
                         input logic drop_early,
                         output logic a1, output logic a2, output logic e2, output logic [31:0] r2,
                         output logic a3, output logic [31:0] r3,
                         output logic xe, output logic [31:0] xr);
    bus_req = 1'b1; bus_device = dev; bus_command = cmd; bus_wdata = wdata;
    tick();
    a1 = bus_ack;
    loc_rx_ready = lpop; loc_tx_valid = lpush; loc_tx_data = lpd;
    if (drop_early) bus_req = 1'b0;
    model_exec(cmd, wdata, lpop, lpush, lpd, xe, xr);
    tick();
    a2 = bus_ack; e2 = bus_err; r2 = bus_rdata;
    loc_rx_ready = 1'b0; loc_tx_valid = 1'b0; bus_req = 1'b0;
    tick();
    a3 = bus_ack; r3 = bus_rdata;
  endtask

  task automatic loc_push(input logic [31:0] d);
    loc_tx_valid = 1'b1; loc_tx_data = d;
    if (txq.size() < DEPTH) txq.push_back(d);
    tick();
    loc_tx_valid = 1'b0;
  endtask

  task automatic loc_pop();
    loc_rx_ready = 1'b1;
    if (rxq.size() > 0) void'(rxq.pop_front());
    tick();
    loc_rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rxq.delete();
    txq.delete();
    tick();
  endtask

  task automatic test_reset();
    logic [4:0] v;
    reset = 1'b1;
    bus_req = 1'b0; bus_device = '0; bus_command = '0; bus_wdata = '0;
    loc_rx_ready = 1'b0; loc_tx_valid = 1'b0; loc_tx_data = '0;
    tick(); tick();
    v = {bus_ack, bus_err, (bus_rdata != 0), loc_rx_valid, loc_tx_ready};
    checks++;
    if (v !== 5'b00001) $display("FAIL reset_outputs ack,err,rdata!=0,rx_valid,tx_ready got %b exp 00001", v);
    else passed++;
    reset = 1'b0;
    rxq.delete(); txq.delete();
    tick();
  endtask

  task automatic test_write_basic();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr;
    bus_txn(5'd1, WR, 32'hDEADBEEF, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if ({a1, a2, e2, a3} !== 4'b0100) $display("FAIL write_handshake a1,a2,err,a3 got %b exp 0100", {a1, a2, e2, a3}); else passed++;
    checks++; if (loc_rx_valid !== 1'b1) $display("FAIL write_rx_valid got %b exp 1", loc_rx_valid); else passed++;
    checks++; if (loc_rx_data !== 32'hDEADBEEF) $display("FAIL write_rx_data got %h exp deadbeef", loc_rx_data); else passed++;
    loc_pop();
    checks++; if (loc_rx_valid !== 1'b0) $display("FAIL write_rx_drained got %b exp 0", loc_rx_valid); else passed++;
  endtask

  task automatic test_ack_hold();
    bus_req = 1'b1; bus_device = 5'd1; bus_command = ST;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_ack !== 1'b1) $display("FAIL ack_hold cycle %0d got %b exp 1", i, bus_ack); else passed++;
      tick();
    end
    bus_req = 1'b0;
    tick();
    checks++; if ({bus_ack, bus_rdata} !== 33'd0) $display("FAIL ack_release got ack=%b rdata=%h exp 0/0", bus_ack, bus_rdata); else passed++;
  endtask

  task automatic test_read();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr;
    logic [31:0] exp_r [3] = '{32'h11, 32'h22, 32'h0};
    logic        exp_e [3] = '{1'b0, 1'b0, 1'b1};
    loc_push(32'h11);
    loc_push(32'h22);
    for (int i = 0; i < 3; i++) begin
      bus_txn(5'd1, RD, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
      checks++;
      if ({a2, e2, r2} !== {1'b1, exp_e[i], exp_r[i]})
        $display("FAIL read_%0d got ack=%b err=%b rdata=%h exp 1/%b/%h", i, a2, e2, r2, exp_e[i], exp_r[i]);
      else passed++;
    end
  endtask

  task automatic test_full_wrap();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr, d;
    logic [31:0] sent[$];
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      if (i < 4) sent.push_back(d);
      bus_txn(5'd1, WR, d, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
      checks++;
      if ({a2, e2} !== {1'b1, (i == 4)}) $display("FAIL fill_write_%0d got ack=%b err=%b exp 1/%b", i, a2, e2, (i == 4));
      else passed++;
    end
    bus_txn(5'd1, ST, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if (r2 !== 32'h0003_0004 || e2 !== 1'b0) $display("FAIL full_status got err=%b rdata=%h exp 0/00030004", e2, r2); else passed++;
    for (int round = 0; round < 2; round++) begin
      if (round == 1) begin
        for (int i = 0; i < 4; i++) begin
          d = $urandom;
          sent.push_back(d);
          bus_txn(5'd1, WR, d, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
        end
      end
      for (int i = 0; i < 4; i++) begin
        d = sent.pop_front();
        checks++;
        if ({loc_rx_valid, loc_rx_data} !== {1'b1, d})
          $display("FAIL drain_r%0d_%0d got valid=%b data=%h exp 1/%h", round, i, loc_rx_valid, loc_rx_data, d);
        else passed++;
        loc_pop();
      end
    end
  endtask

  task automatic test_ignore_illegal();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr;
    bus_req = 1'b1; bus_device = 5'd2; bus_command = WR; bus_wdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({bus_ack, bus_rdata} !== 33'd0) $display("FAIL other_dev cycle %0d got ack=%b rdata=%h exp 0/0", i, bus_ack, bus_rdata);
      else passed++;
    end
    bus_req = 1'b0;
    tick();
    loc_push(32'h77);
    bus_txn(5'd1, 6'h3F, 32'h1234, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if ({a2, e2, r2} !== {2'b11, 32'h0}) $display("FAIL illegal_cmd got ack=%b err=%b rdata=%h exp 1/1/0", a2, e2, r2); else passed++;
    bus_txn(5'd1, ST, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if (r2 !== 32'h0000_0100) $display("FAIL illegal_no_change got %h exp 00000100", r2); else passed++;
    bus_txn(5'd1, RD, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
  endtask

  task automatic test_collision();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr;
    for (int i = 0; i < 4; i++)
      bus_txn(5'd1, WR, 32'hA0 + i, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    bus_txn(5'd1, WR, 32'hBAD, 1'b1, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if (e2 !== 1'b1) $display("FAIL full_write_with_pop err got %b exp 1", e2); else passed++;
    bus_txn(5'd1, ST, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if (r2[4:0] !== 5'd3) $display("FAIL rx_count_after_collision got %0d exp 3", r2[4:0]); else passed++;
    checks++; if (loc_rx_data !== 32'hA1) $display("FAIL rx_head_after_collision got %h exp a1", loc_rx_data); else passed++;
    loc_push(32'hC0);
    loc_push(32'hC1);
    bus_txn(5'd1, RD, '0, 1'b0, 1'b1, 32'hC2, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if ({e2, r2} !== {1'b0, 32'hC0}) $display("FAIL read_with_push got err=%b rdata=%h exp 0/c0", e2, r2); else passed++;
    bus_txn(5'd1, ST, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if (r2[12:8] !== 5'd2) $display("FAIL tx_count_after_collision got %0d exp 2", r2[12:8]); else passed++;
    do_reset();
  endtask

  task automatic test_exec_drop();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr;
    bus_txn(5'd1, WR, 32'hFACE, 1'b0, 1'b0, '0, 1'b1, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if ({a2, e2, a3} !== 3'b100) $display("FAIL exec_drop_pulse a2,err,a3 got %b exp 100", {a2, e2, a3}); else passed++;
    checks++; if ({loc_rx_valid, loc_rx_data} !== {1'b1, 32'hFACE}) $display("FAIL exec_drop_commit got %b/%h exp 1/0000face", loc_rx_valid, loc_rx_data); else passed++;
    loc_pop();
  endtask

  task automatic test_reset_mid();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr;
    bus_txn(5'd1, WR, 32'h1, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    bus_txn(5'd1, WR, 32'h2, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    loc_push(32'h3);
    loc_push(32'h4);
    bus_req = 1'b1; bus_device = 5'd1; bus_command = ST;
    tick(); tick();
    checks++; if (bus_ack !== 1'b1) $display("FAIL pre_reset_ack got %b exp 1", bus_ack); else passed++;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_ack, bus_err, loc_rx_valid, loc_tx_ready, bus_rdata} !== {4'b0001, 32'h0})
      $display("FAIL async_reset ack,err,rx_valid,tx_ready got %b rdata %h exp 0001/0", {bus_ack, bus_err, loc_rx_valid, loc_tx_ready}, bus_rdata);
    else passed++;
    rxq.delete(); txq.delete();
    bus_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    bus_txn(5'd1, WR, 32'h99, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if ({a1, a2, e2, a3} !== 4'b0100) $display("FAIL post_reset_write got %b exp 0100", {a1, a2, e2, a3}); else passed++;
    bus_txn(5'd1, ST, '0, 1'b0, 1'b0, '0, 1'b0, a1, a2, e2, r2, a3, r3, xe, xr);
    checks++; if (r2 !== 32'h0002_0001) $display("FAIL post_reset_status got %h exp 00020001", r2); else passed++;
    loc_pop();
  endtask

  task automatic test_random();
    logic a1, a2, e2, a3, xe;
    logic [31:0] r2, r3, xr, d;
    logic [5:0] cmd;
    int op, sel;
    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 9);
      if (op < 6) begin
        sel = $urandom_range(0, 9);
        cmd = (sel < 4) ? RD : (sel < 8) ? WR : (sel < 9) ? ST : 6'($urandom_range(3, 63));
        bus_txn(5'd1, cmd, $urandom, 1'($urandom), 1'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                a1, a2, e2, r2, a3, r3, xe, xr);
        checks++;
        if ({a1, a2, e2, r2, a3, r3} !== {2'b01, xe, xr, 1'b0, 32'h0})
          $display("FAIL rand_%0d cmd %h got a1=%b a2=%b err=%b rdata=%h a3=%b r3=%h exp 0/1/%b/%h/0/0",
                   it, cmd, a1, a2, e2, r2, a3, r3, xe, xr);
        else passed++;
      end else if (op < 8) begin
        loc_push($urandom);
      end else begin
        d = (rxq.size() > 0) ? rxq[0] : '0;
        checks++;
        if (loc_rx_valid !== (rxq.size() > 0) || (rxq.size() > 0 && loc_rx_data !== d))
          $display("FAIL rand_pop_%0d got valid=%b data=%h exp %b/%h", it, loc_rx_valid, loc_rx_data, (rxq.size() > 0), d);
        else passed++;
        loc_pop();
      end
      checks++;
      if (loc_tx_ready !== (txq.size() < DEPTH))
        $display("FAIL rand_tx_ready_%0d got %b exp %b", it, loc_tx_ready, (txq.size() < DEPTH));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_ack_hold();
    test_read();
    test_full_wrap();
    test_ignore_illegal();
    test_collision();
    test_exec_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
